fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: PC_INIT, 32'h00000000, PC value loaded on reset.
REQ-002 SHALL have port: CLK  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: iREN  output  1  instruction memory read request.
REQ-005 SHALL have port: iaddr  output  32  instruction fetch address, word aligned.
REQ-006 SHALL have port: ihit  input  1  memory data valid on iload this cycle.
REQ-007 SHALL have port: iload  input  32  instruction word from memory.
REQ-008 SHALL have port: imemload  output  32  latched instruction presented to decode.
REQ-009 SHALL have port: instr_valid  output  1  imemload holds a live instruction.
REQ-010 SHALL have port: stall  input  1  downstream not ready; hold current instruction.
REQ-011 SHALL have ports: jmp, jmpr, b_eq, b_ne, hlt  input  1 each  decoded control for imemload.
REQ-012 SHALL have port: zero  input  1  ALU zero flag for branch resolution.
REQ-013 SHALL have port: rs_data  input  32  register rs value, jump-register target.
REQ-014 SHALL have port: pc_plus4  output  32  PC+4 of current instruction, JAL link value.
REQ-015 SHALL have port: halted  output  1  HALT retired; fetch stopped.

Function
REQ-016 SHALL implement states FETCH, HOLD, HALTED; state register, PC, imemload and instr_valid are flops on CLK.
REQ-017 FETCH: iREN=1, iaddr=PC, instr_valid=0; on ihit, imemload<=iload, instr_valid<=1, next state HOLD.
REQ-018 FETCH without ihit: remain in FETCH, iREN and iaddr stable, no PC change.
REQ-019 ihit outside FETCH SHALL be ignored; iload never sampled outside FETCH.
REQ-020 HOLD: iREN=0, instr_valid=1, imemload stable; control inputs sampled only in HOLD.
REQ-021 HOLD with stall=1: remain in HOLD, PC and imemload unchanged, regardless of control inputs.
REQ-022 HOLD with stall=0 SHALL select next PC by priority: hlt > jmpr > jmp > branch taken > PC+4.
REQ-023 hlt=1 (stall=0): PC unchanged, instr_valid<=0, next state HALTED.
REQ-024 Otherwise (stall=0): PC<=next PC, instr_valid<=0, next state FETCH.
REQ-025 jmpr target SHALL be {rs_data[31:2],2'b00}; misaligned low bits are discarded.
REQ-026 jmp target SHALL be {pc_plus4[31:28], imemload[25:0], 2'b00}.
REQ-027 branch taken = (b_eq & zero) | (b_ne & ~zero); target = pc_plus4 + (sign-extended imemload[15:0] << 2).
REQ-028 pc_plus4 SHALL equal PC+4 combinationally in every state.
REQ-029 All PC arithmetic SHALL be 32-bit modulo 2^32: 32'hFFFFFFFC+4 = 0; backward branches may wrap below 0.
REQ-030 HALTED: iREN=0, instr_valid=0, halted=1; remains until RST; all inputs ignored.
REQ-031 Minimum fetch latency: ihit in the first FETCH cycle -> instr_valid=1 on the next cycle; sequential throughput is one instruction per two cycles.

Reset
REQ-032 RST=1 at a CLK edge SHALL force PC<=PC_INIT, imemload<=0, instr_valid<=0, halted<=0, state<=FETCH.
REQ-033 RST SHALL take priority over ihit, stall and all control inputs in every state, including HALTED.
REQ-034 Reset during a pending fetch SHALL drop the request; an ihit in the same cycle as RST SHALL NOT load imemload.
REQ-035 First cycle after RST deasserts: iREN=1, iaddr=PC_INIT.

Verification
REQ-036 Sequential: ihit=1 every FETCH, iload=32'h20010005 at 0, stall=0 -> instr_valid on cycle 2, iaddr 0,4,8 on cycles 1,3,5.
REQ-037 Memory wait: ihit held low 3 cycles at PC=0x10 -> iREN=1, iaddr=0x10 stable 3 cycles; instr_valid rises one cycle after ihit.
REQ-038 Branch: PC=0x20, imemload imm16=16'hFFFE, b_eq=1, zero=1 -> next iaddr=0x1C; same with zero=0 -> 0x24.
REQ-039 Jumps: PC=0x40, imemload[25:0]=26'h100 with jmp=1 -> iaddr 0x400; jmpr=1 with jmp=1, rs_data=0x87 -> iaddr 0x84 (jmpr wins).
REQ-040 Stall and halt: stall=1 for 4 cycles in HOLD with jmp=1 -> PC unchanged; then hlt=1, stall=0 -> halted=1, iREN=0 held 10 cycles.
REQ-041 Reset/wrap: PC=0xFFFFFFFC sequential -> next iaddr 0; RST during HALTED or with ihit=1 -> iaddr=PC_INIT, instr_valid=0, halted=0 next cycle.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
// Latency: none, plain wires.
// Backpressure: memory holds ihit low to stall; the request stays asserted until ihit.
// Signals: iREN (read request), iaddr (word address), ihit (data valid), iload (data).
interface fetch_unit_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        ihit;
    logic [31:0] iload;

    modport master (output iREN, iaddr, input ihit, iload);
    modport slave  (input iREN, iaddr, output ihit, iload);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: fetches one word, holds it for decode, then steers the PC.
// Latency: instr_valid rises the cycle after ihit; sequential throughput is one instruction per two cycles.
// Backpressure: stall=1 freezes the held instruction and PC; a missing ihit keeps the request pending.
// Ports: CLK/RST (sync, active-high); imem = memory bus (master side);
//        imemload/instr_valid = held instruction to decode; stall, jmp, jmpr, b_eq,
//        b_ne, hlt, zero, rs_data = decode/ALU feedback; pc_plus4 = link value;
//        halted = HALT retired.
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic                CLK,
    input  logic                RST,
    fetch_unit_if.master        imem,
    output logic [31:0]         imemload,
    output logic                instr_valid,
    input  logic                stall,
    input  logic                jmp,
    input  logic                jmpr,
    input  logic                b_eq,
    input  logic                b_ne,
    input  logic                hlt,
    input  logic                zero,
    input  logic [31:0]         rs_data,
    output logic [31:0]         pc_plus4,
    output logic                halted
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_imemload;
    logic        r_instr_valid;

    logic [31:0] w_next_pc;
    logic [31:0] w_br_offset;
    logic [31:0] w_br_target;
    logic [31:0] w_jmp_target;
    logic [31:0] w_jr_target;
    logic        w_br_taken;
    logic        w_unused_rs;

    // ---------------- state register ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FETCH:   if (imem.ihit) w_next_state = HOLD;
            HOLD:    if (!stall)    w_next_state = hlt ? HALTED : FETCH;
            HALTED:  w_next_state = HALTED;
            default: w_next_state = FETCH;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        imem.iREN = (r_state == FETCH);
        imem.iaddr = r_pc;
        halted = (r_state == HALTED);
    end

    // ---------------- PC datapath ----------------
    assign pc_plus4     = r_pc + 32'd4;
    assign w_br_offset  = {{14{r_imemload[15]}}, r_imemload[15:0], 2'b00};
    assign w_br_target  = pc_plus4 + w_br_offset;
    assign w_jmp_target = {pc_plus4[31:28], r_imemload[25:0], 2'b00};
    // Low bits of the register target are dropped to keep fetches word aligned.
    assign w_jr_target  = {rs_data[31:2], 2'b00};
    assign w_unused_rs  = ^rs_data[1:0];
    assign w_br_taken   = (b_eq & zero) | (b_ne & ~zero);

    // Halt keeps the PC pointing at the HALT instruction.
    always_comb begin
        w_next_pc = pc_plus4;
        if (hlt) begin
            w_next_pc = r_pc;
        end else if (jmpr) begin
            w_next_pc = w_jr_target;
        end else if (jmp) begin
            w_next_pc = w_jmp_target;
        end else if (w_br_taken) begin
            w_next_pc = w_br_target;
        end
    end

    // iload is only captured while a request is outstanding; control inputs
    // only matter while an instruction is held and decode is ready.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pc          <= PC_INIT;
            r_imemload    <= 32'h0;
            r_instr_valid <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (imem.ihit) begin
                        r_imemload    <= imem.iload;
                        r_instr_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        r_pc          <= w_next_pc;
                        r_instr_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imemload    = r_imemload;
    assign instr_valid = r_instr_valid;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] PC_INIT = 32'h0000_0000;

    // ctl encoding used by the bench: {hlt, jmpr, jmp, b_eq, b_ne}
    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_BNE  = 5'b00001;
    localparam logic [4:0] C_BEQ  = 5'b00010;
    localparam logic [4:0] C_JMP  = 5'b00100;
    localparam logic [4:0] C_JR   = 5'b01000;

    logic        CLK = 1'b0;
    logic        RST;
    logic        stall, jmp, jmpr, b_eq, b_ne, hlt, zero;
    logic [31:0] rs_data;
    logic [31:0] imemload;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        halted;

    fetch_unit_if imem();

    fetch_unit #(.PC_INIT(PC_INIT)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .imem        (imem),
        .imemload    (imemload),
        .instr_valid (instr_valid),
        .stall       (stall),
        .jmp         (jmp),
        .jmpr        (jmpr),
        .b_eq        (b_eq),
        .b_ne        (b_ne),
        .hlt         (hlt),
        .zero        (zero),
        .rs_data     (rs_data),
        .pc_plus4    (pc_plus4),
        .halted      (halted)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // m_live: an instruction is being presented; m_halt: HALT has retired.
    logic [31:0] m_pc, m_instr;
    bit          m_live, m_halt;

    task automatic model_edge();
        logic [31:0] seq, off, nxt;
        if (RST) begin
            m_pc = PC_INIT; m_instr = 32'h0; m_live = 0; m_halt = 0;
        end else if (m_halt) begin
            m_halt = 1;
        end else if (!m_live) begin
            if (imem.ihit) begin
                m_instr = imem.iload;
                m_live  = 1;
            end
        end else if (!stall) begin
            seq = m_pc + 32'd4;
            if (hlt) begin
                m_halt = 1;
            end else begin
                if (jmpr)
                    nxt = rs_data & ~32'd3;
                else if (jmp)
                    nxt = (seq & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 32'd4);
                else if ((b_eq && zero) || (b_ne && !zero)) begin
                    off = 32'($signed(m_instr[15:0]));
                    nxt = seq + off * 32'd4;
                end else
                    nxt = seq;
                m_pc = nxt;
            end
            m_live = 0;
        end
    endtask

    task automatic drive(input logic rst, input logic ihit, input logic [31:0] iload,
                         input logic st, input logic [4:0] ctl, input logic z,
                         input logic [31:0] rs);
        RST = rst; imem.ihit = ihit; imem.iload = iload; stall = st;
        {hlt, jmpr, jmp, b_eq, b_ne} = ctl; zero = z; rs_data = rs;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst, ihit, stall, zero;
        logic [4:0]  ctl;
        logic [31:0] iload, rs;
        logic        e_iren, e_valid, e_halted;
        logic [31:0] e_pc, e_imem;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic ihit, input logic [31:0] iload,
                                input logic st, input logic [4:0] ctl, input logic z,
                                input logic [31:0] rs, input logic e_iren,
                                input logic [31:0] e_pc, input logic e_valid,
                                input logic [31:0] e_imem, input logic e_halted);
        vec_t v;
        v.rst = rst; v.ihit = ihit; v.iload = iload; v.stall = st; v.ctl = ctl;
        v.zero = z; v.rs = rs; v.e_iren = e_iren; v.e_pc = e_pc;
        v.e_valid = e_valid; v.e_imem = e_imem; v.e_halted = e_halted;
        return v;
    endfunction

    initial begin
        drive(1'b1, 1'b0, 32'h0, 1'b0, C_NONE, 1'b0, 32'h0);

        //               rst ihit iload         st ctl     z  rs            iren pc            vld imem          hlt
        vecs.push_back(mk(1, 0, 32'h0,         0, C_NONE, 0, 32'h0,        1, 32'h0,         0, 32'h0,         0));
        vecs.push_back(mk(0, 1, 32'h20010005,  0, C_NONE, 0, 32'h0,        0, 32'h0,         1, 32'h20010005,  0));
        vecs.push_back(mk(0, 0, 32'h0,         0, C_NONE, 0, 32'h0,        1, 32'h4,         0, 32'h20010005,  0));
        vecs.push_back(mk(0, 1, 32'h11111111,  0, C_NONE, 0, 32'h0,        0, 32'h4,         1, 32'h11111111,  0));
        vecs.push_back(mk(0, 0, 32'h0,         0, C_NONE, 0, 32'h0,        1, 32'h8,         0, 32'h11111111,  0));
        vecs.push_back(mk(0, 1, 32'h22222222,  0, C_NONE, 0, 32'h0,        0, 32'h8,         1, 32'h22222222,  0));
        vecs.push_back(mk(0, 0, 32'h0,         0, C_JR,   0, 32'h10,       1, 32'h10,        0, 32'h22222222,  0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0, 0, 32'h33333333, 0, C_NONE, 0, 32'h0,     1, 32'h10,        0, 32'h22222222,  0));
        vecs.push_back(mk(0, 1, 32'h1000FFFE,  0, C_NONE, 0, 32'h0,        0, 32'h10,        1, 32'h1000FFFE,  0));
        vecs.push_back(mk(0, 1, 32'hDEADBEEF,  1, C_JMP,  0, 32'h0,        0, 32'h10,        1, 32'h1000FFFE,  0));
        vecs.push_back(mk(0, 0, 32'h0,         0, C_JR,   0, 32'h20,       1, 32'h20,        0, 32'h1000FFFE,  0));
        vecs.push_back(mk(0, 1, 32'h1000FFFE,  0, C_NONE, 0, 32'h0,        0, 32'h20,        1, 32'h1000FFFE,  0));
        vecs.push_back(mk(0, 0, 32'h0,         0, C_BEQ,  1, 32'h0,        1, 32'h1C,        0, 32'h1000FFFE,  0));
        vecs.push_back(mk(0, 1, 32'h44444444,  0, C_NONE, 0, 32'h0,        0, 32'h1C,        1, 32'h44444444,  0));
        vecs.push_back(mk(0, 0, 32'h0,         0, C_JR,   0, 32'h20,       1, 32'h20,        0, 32'h44444444,  0));
        vecs.push_back(mk(0, 1, 32'h1000FFFE,  0, C_NONE, 0, 32'h0,        0, 32'h20,        1, 32'h1000FFFE,  0));
        vecs.push_back(mk(0, 0, 32'h0,         0, C_BEQ,  0, 32'h0,        1, 32'h24,        0, 32'h1000FFFE,  0));
        vecs.push_back(mk(0, 1, 32'h14000003,  0, C_NONE, 0, 32'h0,        0, 32'h24,        1, 32'h14000003,  0));
        vecs.push_back(mk(0, 0, 32'h0,         0, C_BNE,  0, 32'h0,        1, 32'h34,        0, 32'h14000003,  0));
        vecs.push_back(mk(0, 1, 32'h55555555,  0, C_NONE, 0, 32'h0,        0, 32'h34,        1, 32'h55555555,  0));
        vecs.push_back(mk(0, 0, 32'h0,         0, C_JR,   0, 32'h40,       1, 32'h40,        0, 32'h55555555,  0));
        vecs.push_back(mk(0, 1, 32'h08000100,  0, C_NONE, 0, 32'h0,        0, 32'h40,        1, 32'h08000100,  0));
        vecs.push_back(mk(0, 0, 32'h0,         0, C_JMP,  0, 32'h0,        1, 32'h400,       0, 32'h08000100,  0));
        vecs.push_back(mk(0, 1, 32'h08000100,  0, C_NONE, 0, 32'h0,        0, 32'h400,       1, 32'h08000100,  0));
        vecs.push_back(mk(0, 0, 32'h0,         0, C_JR|C_JMP, 0, 32'h87,   1, 32'h84,        0, 32'h08000100,  0));
        vecs.push_back(mk(0, 1, 32'h08000100,  0, C_NONE, 0, 32'h0,        0, 32'h84,        1, 32'h08000100,  0));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0, 1, 32'h99999999, 1, C_JMP, 0, 32'h0,      0, 32'h84,        1, 32'h08000100,  0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 5'b11111, 1, 32'h87,     0, 32'h84,        0, 32'h08000100,  1));
        for (int k = 0; k < 10; k++)
            vecs.push_back(mk(0, 1, 32'h66666666, 0, C_JR|C_JMP, 1, 32'h100, 0, 32'h84,      0, 32'h08000100,  1));
        vecs.push_back(mk(1, 1, 32'h77777777,  0, C_NONE, 0, 32'h0,        1, 32'h0,         0, 32'h0,         0));
        vecs.push_back(mk(0, 1, 32'h88888888,  0, C_NONE, 0, 32'h0,        0, 32'h0,         1, 32'h88888888,  0));
        vecs.push_back(mk(0, 0, 32'h0,         0, C_JR,   0, 32'hFFFFFFFF, 1, 32'hFFFFFFFC,  0, 32'h88888888,  0));
        vecs.push_back(mk(0, 1, 32'h12345678,  0, C_NONE, 0, 32'h0,        0, 32'hFFFFFFFC,  1, 32'h12345678,  0));
        vecs.push_back(mk(0, 0, 32'h0,         0, C_NONE, 0, 32'h0,        1, 32'h0,         0, 32'h12345678,  0));
        vecs.push_back(mk(1, 1, 32'hCAFEF00D,  0, C_NONE, 0, 32'h0,        1, 32'h0,         0, 32'h0,         0));
        vecs.push_back(mk(0, 1, 32'h0000FFF0,  0, C_NONE, 0, 32'h0,        0, 32'h0,         1, 32'h0000FFF0,  0));
        vecs.push_back(mk(0, 0, 32'h0,         0, C_BEQ,  1, 32'h0,        1, 32'hFFFFFFC4,  0, 32'h0000FFF0,  0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].ihit, vecs[i].iload, vecs[i].stall,
                  vecs[i].ctl, vecs[i].zero, vecs[i].rs);
            tick();
            chk($sformatf("v%0d_iREN", i),     {31'h0, imem.iREN},   {31'h0, vecs[i].e_iren});
            chk($sformatf("v%0d_valid", i),    {31'h0, instr_valid}, {31'h0, vecs[i].e_valid});
            chk($sformatf("v%0d_halted", i),   {31'h0, halted},      {31'h0, vecs[i].e_halted});
            chk($sformatf("v%0d_imemload", i), imemload,             vecs[i].e_imem);
            chk($sformatf("v%0d_pc_plus4", i), pc_plus4,             vecs[i].e_pc + 32'd4);
            if (vecs[i].e_iren)
                chk($sformatf("v%0d_iaddr", i), imem.iaddr,          vecs[i].e_pc);
        end

        // ---------------- randomized phase against the model ----------------
        drive(1'b1, 1'b0, 32'h0, 1'b0, C_NONE, 1'b0, 32'h0);
        tick();
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 49) == 0,
                  1'($urandom_range(0, 1)),
                  $urandom,
                  $urandom_range(0, 3) == 0,
                  {$urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 3) == 0},
                  1'($urandom_range(0, 1)),
                  $urandom);
            tick();
            chk($sformatf("r%0d_iREN", c),     {31'h0, imem.iREN},   {31'h0, !m_live && !m_halt});
            chk($sformatf("r%0d_valid", c),    {31'h0, instr_valid}, {31'h0, m_live});
            chk($sformatf("r%0d_halted", c),   {31'h0, halted},      {31'h0, m_halt});
            chk($sformatf("r%0d_imemload", c), imemload,             m_instr);
            chk($sformatf("r%0d_pc_plus4", c), pc_plus4,             m_pc + 32'd4);
            if (!m_live && !m_halt)
                chk($sformatf("r%0d_iaddr", c), imem.iaddr,          m_pc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
